result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit is driven; legal range is 2 or greater.
REQ-002 SHALL have parameter BLANK_LEAD, default 1, meaning that when 1, a zero tens digit is blanked.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port Result, input, 4, the ALU result value.
REQ-006 SHALL have port cout, input, 1, the ALU carry flag.
REQ-007 SHALL have port borrow, input, 1, the ALU borrow flag.
REQ-008 SHALL have port led_done, input, 1, the ALU done indicator; its rising edge means Result and the flags are valid.
REQ-009 SHALL have port clear, input, 1, a synchronous request to discard the captured value.
REQ-010 SHALL have port seg, output, 7, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an, output, 4, active-low one-hot digit enables, with an[0] as the rightmost digit.
REQ-012 SHALL have port valid, output, 1, high while a captured value is held.

Function
REQ-013 SHALL capture {Result, cout, borrow} into holding registers in the cycle where led_done=1 and the registered previous led_done=0; an input held high causes no re-capture.
REQ-014 SHALL give clear priority over capture when both occur in the same cycle: the holding registers are zeroed, valid=0, and the edge is consumed.
REQ-015 SHALL set valid=1 in the cycle after a capture and hold it until reset or clear.
REQ-016 SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; at terminal count, the 2-bit digit index increments mod 4 (3 wraps to 0).
REQ-017 SHALL keep the prescaler and digit index running regardless of valid, capture or clear.
REQ-018 SHALL register an and seg, updating them one cycle after the digit index changes; an is ~(1 << index).
REQ-019 SHALL set digit 0 to the ones digit of the held value (value - 10 if value >= 10, else value).
REQ-020 SHALL set digit 1 to the tens digit (1 if value >= 10, else 0); it is blank when tens=0 and BLANK_LEAD=1.
REQ-021 SHALL set digit 2 to the flag glyph: 'C' if only cout, 'b' if only borrow, 'E' if both, blank if neither.
REQ-022 SHALL set digit 3 to the hex glyph of the held value (0-F).
REQ-023 SHALL drive an=4'b1111 and seg=7'h7F while valid=0, even though scanning continues.
REQ-024 SHALL use this active-low glyph encoding: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E, blank=7F.
REQ-025 SHALL leave the display unchanged when Result, cout or borrow change without a led_done rising edge.
REQ-026 SHALL make a new capture visible no later than the next digit refresh, with a worst case of 4*SCAN_DIV+2 cycles per digit.

Reset
REQ-027 SHALL, while reset=1, force prescaler=0, digit index=0, valid=0, holding registers=0, an=4'b1111 and seg=7'h7F.
REQ-028 SHALL force previous-led_done=1 during reset, so a led_done held high through reset release produces no capture.
REQ-029 SHALL give reset priority over clear and capture, and SHALL abort any scan in progress.
REQ-030 SHALL, after reset deassertion, start the first digit period at index 0, with an=4'b1110 asserted only once valid=1.

Verification (SCAN_DIV=4, BLANK_LEAD=1)
REQ-031 SHALL cover: Result=4'd13, cout=1, pulse led_done -> valid=1 next cycle; scan shows an[0]: seg=30 ('3'), an[1]: 79 ('1'), an[2]: 46 ('C'), an[3]: 21 ('d').
REQ-032 SHALL cover: Result=4'd5, borrow=1, led_done edge -> an[1] digit seg=7F (blanked), an[2] seg=03 ('b'), an[0] seg=12.
REQ-033 SHALL cover: led_done held high 20 cycles while Result changes 3->9 after the edge -> display keeps 3; a second edge captures 9.
REQ-034 SHALL cover: clear and led_done edge in the same cycle -> valid=0, an=1111, seg=7F; a later edge captures normally.
REQ-035 SHALL cover: led_done=1 across reset release -> no capture and valid stays 0; reset asserted mid-scan at index 2 -> next cycle an=1111 and index 0.
REQ-036 SHALL cover: scan timing -> each an value is held exactly 4 cycles, and the order 1110, 1101, 1011, 0111 repeats.

Source files
------------

// File: rtl/result_display.sv
// Four-digit multiplexed seven-segment readout of a latched 4-bit ALU result and its carry/borrow flags.
// Capture happens on the rising edge of led_done. The digit scan free-runs, and the display stays dark until a value is held.
module result_display #(
   parameter int SCAN_DIV   = 50000,
   parameter bit BLANK_LEAD = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Result,
   input  logic       cout,
   input  logic       borrow,
   input  logic       led_done,
   input  logic       clear,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       valid
);

   localparam int                CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0]        BLANK    = 7'h7F;

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] flag_glyph(input logic c, input logic b);
      logic [6:0] g;
      case ({c, b})
         2'b10:   g = 7'h46;
         2'b01:   g = 7'h03;
         2'b11:   g = 7'h06;
         default: g = BLANK;
      endcase
      return g;
   endfunction

   logic             done_p0;
   logic [3:0]       val_p0;
   logic             cout_p0;
   logic             borrow_p0;
   logic             vld_p0;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             done_rise;
   logic             tens;
   logic [3:0]       ones;
   logic [6:0]       glyph_nxt;

   assign done_rise = led_done & ~done_p0;
   assign valid     = vld_p0;

   // Stage p0: edge detect and holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         done_p0   <= 1'b1;
         val_p0    <= 4'd0;
         cout_p0   <= 1'b0;
         borrow_p0 <= 1'b0;
         vld_p0    <= 1'b0;
      end else begin
         done_p0 <= led_done;
         if (clear) begin
            val_p0    <= 4'd0;
            cout_p0   <= 1'b0;
            borrow_p0 <= 1'b0;
            vld_p0    <= 1'b0;
         end else if (done_rise) begin
            val_p0    <= Result;
            cout_p0   <= cout;
            borrow_p0 <= borrow;
            vld_p0    <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      tens      = (val_p0 >= 4'd10);
      ones      = tens ? (val_p0 - 4'd10) : val_p0;
      glyph_nxt = BLANK;
      case (idx)
         2'd0:    glyph_nxt = hex_glyph(ones);
         2'd1:    glyph_nxt = (!tens && BLANK_LEAD) ? BLANK : hex_glyph({3'b000, tens});
         2'd2:    glyph_nxt = flag_glyph(cout_p0, borrow_p0);
         default: glyph_nxt = hex_glyph(val_p0);
      endcase
   end

   // Stage p1: registered digit drive, dark while nothing is held
   always_ff @(posedge clk) begin
      if (reset || !vld_p0) begin
         an  <= 4'b1111;
         seg <= BLANK;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= glyph_nxt;
      end
   end

endmodule

// File: tb/tb_result_display.sv
// Randomized and directed bench for result_display, using a cycle-level behavioural model and a scoreboard queue.
module tb_result_display;

   localparam int SCAN_DIV   = 4;
   localparam bit BLANK_LEAD = 1'b1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Result = 4'd0;
   logic       cout = 1'b0;
   logic       borrow = 1'b0;
   logic       led_done = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       valid;

   result_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LEAD(BLANK_LEAD)) dut (
      .clk(clk), .reset(reset), .Result(Result), .cout(cout), .borrow(borrow),
      .led_done(led_done), .clear(clear), .seg(seg), .an(an), .valid(valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       valid;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [6:0] glyph_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [6:0] shown [0:3];

   // Behavioural reference: cycles since reset, the held value and its flags.
   int m_count;
   int m_val;
   bit m_cout, m_borrow, m_valid, m_prev_done;

   function automatic exp_t model_display();
      exp_t e;
      int   d;
      d = (m_count / SCAN_DIV) % 4;
      e.valid = 1'b0;
      e.an    = 4'hF;
      e.seg   = 7'h7F;
      if (m_valid) begin
         e.an = ~(4'b0001 << d);
         case (d)
            0: e.seg = glyph_tab[m_val % 10];
            1: e.seg = (m_val / 10 == 0 && BLANK_LEAD) ? 7'h7F : glyph_tab[m_val / 10];
            2: e.seg = (m_cout && m_borrow) ? 7'h06 : m_cout ? 7'h46 : m_borrow ? 7'h03 : 7'h7F;
            default: e.seg = glyph_tab[m_val];
         endcase
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      @(posedge clk);
      if (reset) begin
         e = '{an: 4'hF, seg: 7'h7F, valid: 1'b0};
         m_count = 0; m_val = 0; m_cout = 0; m_borrow = 0; m_valid = 0; m_prev_done = 1;
      end else begin
         e = model_display();
         m_count++;
         if (clear) begin
            m_val = 0; m_cout = 0; m_borrow = 0; m_valid = 0;
         end else if (led_done && !m_prev_done) begin
            m_val = int'(Result); m_cout = cout; m_borrow = borrow; m_valid = 1;
         end
         m_prev_done = led_done;
         e.valid = m_valid;
      end
      exp_q.push_back(e);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ({an, seg, valid} !== e) begin
            n_bad++;
            $display("FAIL disp t=%0t got an=%b seg=%h valid=%b want an=%b seg=%h valid=%b",
                     $time, an, seg, valid, e.an, e.seg, e.valid);
         end
         case (an)
            4'b1110: shown[0] = seg;
            4'b1101: shown[1] = seg;
            4'b1011: shown[2] = seg;
            4'b0111: shown[3] = seg;
            default: ;
         endcase
      end
   end

   task automatic clear_shown();
      for (int i = 0; i < 4; i++) shown[i] = 7'h55;
   endtask

   task automatic check_shown(input string name, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3);
      logic [6:0] want [0:3];
      want[0] = d0; want[1] = d1; want[2] = d2; want[3] = d3;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (shown[i] !== want[i]) begin
            n_bad++;
            $display("FAIL %s digit%0d got seg=%h want seg=%h", name, i, shown[i], want[i]);
         end
      end
   endtask

   task automatic check_valid(input string name, input logic want);
      n_cmp++;
      if (valid !== want) begin
         n_bad++;
         $display("FAIL %s got valid=%b want valid=%b", name, valid, want);
      end
   endtask

   task automatic edge_capture(input logic [3:0] r, input logic c, input logic b);
      led_done = 1'b0; Result = r; cout = c; borrow = b;
      step();
      led_done = 1'b1;
      step();
      led_done = 1'b0;
   endtask

   initial begin
      // Reset with led_done high across release: no capture
      reset = 1'b1; led_done = 1'b1;
      run(3);
      reset = 1'b0;
      run(10);
      check_valid("no_capture_reset_release", 1'b0);

      // 13 with carry
      edge_capture(4'd13, 1'b1, 1'b0);
      check_valid("valid_after_capture", 1'b1);
      clear_shown();
      run(20);
      check_shown("r13_cout", 7'h30, 7'h79, 7'h46, 7'h21);

      // 5 with borrow, tens blanked
      edge_capture(4'd5, 1'b0, 1'b1);
      clear_shown();
      run(20);
      check_shown("r5_borrow", 7'h12, 7'h7F, 7'h03, 7'h12);

      // Held led_done while Result changes, then a second edge
      led_done = 1'b0; Result = 4'd3; cout = 1'b0; borrow = 1'b0;
      step();
      led_done = 1'b1;
      step();
      Result = 4'd9;
      run(19);
      clear_shown();
      run(16);
      check_shown("held_high_keeps3", 7'h30, 7'h7F, 7'h7F, 7'h30);
      edge_capture(4'd9, 1'b0, 1'b0);
      clear_shown();
      run(20);
      check_shown("second_edge9", 7'h10, 7'h7F, 7'h7F, 7'h10);

      // Clear and edge together
      led_done = 1'b0;
      step();
      clear = 1'b1; led_done = 1'b1; Result = 4'd7;
      step();
      clear = 1'b0;
      run(5);
      check_valid("clear_wins", 1'b0);
      edge_capture(4'd10, 1'b1, 1'b1);
      run(20);

      // Reset mid-scan at index 2
      for (int i = 0; i < 16 && ((m_count / SCAN_DIV) % 4) != 2; i++) step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      run(20);
      edge_capture(4'd15, 1'b0, 1'b0);
      run(20);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         Result   = 4'($urandom_range(0, 15));
         cout     = 1'($urandom_range(0, 1));
         borrow   = 1'($urandom_range(0, 1));
         led_done = ($urandom_range(0, 9) < 3);
         clear    = ($urandom_range(0, 59) == 0);
         reset    = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0; clear = 1'b0; led_done = 1'b0;
      run(4);

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
